// File: rtl/bcd_d.sv
// rtl/bcd_d.sv - iterative BCD-to-binary converter (reverse double-dabble), one step per clock.
// Optional BCD_D_OVF8_EN adds Ovf: result does not fit in 8 bits.
module bcd_d #(
  parameter int BIN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       Units,
  input  logic [3:0]       Tens,
  input  logic [3:0]       Hunds,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] Bin,
  output logic             Err
`ifdef BCD_D_OVF8_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        sreg_q, sreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
`ifdef BCD_D_OVF8_EN
  logic               ovf_q, ovf_d;
`endif

  logic [11:0]        sreg_sh;
  logic [BIN_W-1:0]   acc_sh;
  logic               digit_bad;

  // Halving a BCD digit moves 10/2=5 into the lower nibble as weight 8; subtract 3 to make it 5.
  function automatic logic [3:0] fix_nib(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  always_comb begin
    sreg_sh   = {1'b0, sreg_q[11:1]};
    acc_sh    = {sreg_q[0], acc_q[BIN_W-1:1]};
    sreg_sh   = {fix_nib(sreg_sh[11:8]), fix_nib(sreg_sh[7:4]), fix_nib(sreg_sh[3:0])};
    digit_bad = (Hunds > 4'd9) || (Tens > 4'd9) || (Units > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
`ifdef BCD_D_OVF8_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
`ifdef BCD_D_OVF8_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
`ifdef BCD_D_OVF8_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (digit_bad) begin
            bin_d   = '0;
            err_d   = 1'b1;
`ifdef BCD_D_OVF8_EN
            ovf_d   = 1'b0;
`endif
            state_d = S_DONE;
          end else begin
            sreg_d  = {Hunds, Tens, Units};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_sh;
        acc_d  = acc_sh;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = acc_sh;
          err_d   = 1'b0;
`ifdef BCD_D_OVF8_EN
          ovf_d   = (acc_sh > BIN_W'(255));
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign Bin = bin_q;
  assign Err = err_q;
`ifdef BCD_D_OVF8_EN
  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bcd_d.sv
// tb/tb_bcd_d.sv - directed table-driven bench for bcd_d (default BIN_W=10).
module tb_bcd_d;

  localparam int BIN_W = 10;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       Units, Tens, Hunds;
  logic             busy, done, Err;
  logic [BIN_W-1:0] Bin;
`ifdef BCD_D_OVF8_EN
  logic             Ovf;
`endif

  int checks;
  int failures;

  bcd_d #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Units (Units),
    .Tens  (Tens),
    .Hunds (Hunds),
    .busy  (busy),
    .done  (done),
    .Bin   (Bin),
    .Err   (Err)
`ifdef BCD_D_OVF8_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    int         bin;
    int         err;
    int         ovf;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the accepting edge; lat = edges after accept until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) begin
      lat = -1;
    end
  endtask

  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         output int lat);
    Hunds = h; Tens = t; Units = u;
    start = 1'b1;
    tick();
    start = 1'b0;
    Hunds = 4'h0; Tens = 4'h0; Units = 4'h0;
    chk("busy_after_accept", int'(busy), 1);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int seen;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    Units = 4'h0; Tens = 4'h0; Hunds = 4'h0;

    vecs[0]  = '{4'd2, 4'd5, 4'd5, 255, 0, 0, BIN_W};
    vecs[1]  = '{4'd9, 4'd9, 4'd9, 999, 0, 1, BIN_W};
    vecs[2]  = '{4'd2, 4'd5, 4'd6, 256, 0, 1, BIN_W};
    vecs[3]  = '{4'd0, 4'd0, 4'd0, 0,   0, 0, BIN_W};
    vecs[4]  = '{4'd1, 4'hA, 4'd3, 0,   1, 0, 0};
    vecs[5]  = '{4'd1, 4'd2, 4'd3, 123, 0, 0, BIN_W};
    vecs[6]  = '{4'hF, 4'd0, 4'd0, 0,   1, 0, 0};
    vecs[7]  = '{4'd0, 4'd9, 4'd9, 99,  0, 0, BIN_W};
    vecs[8]  = '{4'd3, 4'd0, 4'hA, 0,   1, 0, 0};
    vecs[9]  = '{4'd5, 4'd0, 4'd0, 500, 0, 1, BIN_W};
    vecs[10] = '{4'd8, 4'd8, 4'd8, 888, 0, 1, BIN_W};

    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_bin",  int'(Bin),  0);
    chk("reset_err",  int'(Err),  0);
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].h, vecs[i].t, vecs[i].u, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_bin", i), int'(Bin), vecs[i].bin);
      chk($sformatf("v%0d_err", i), int'(Err), vecs[i].err);
`ifdef BCD_D_OVF8_EN
      chk($sformatf("v%0d_ovf", i), int'(Ovf), vecs[i].ovf);
`endif
      chk($sformatf("v%0d_done_busy", i), int'(busy), 1);
      tick();
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_bin_held", i), int'(Bin), vecs[i].bin);
    end

    // start held high, digits changed mid-conversion, automatic restart after DONE
    Hunds = 4'd2; Tens = 4'd5; Units = 4'd5;
    start = 1'b1;
    tick();
    Hunds = 4'd4; Tens = 4'd5; Units = 4'd6;
    wait_done(lat);
    chk("held_first_latency", lat, BIN_W);
    chk("held_first_bin", int'(Bin), 255);
    tick();
    chk("held_idle_gap_busy", int'(busy), 0);
    tick();
    chk("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(lat);
    chk("held_second_latency", lat, BIN_W);
    chk("held_second_bin", int'(Bin), 456);
    chk("held_second_err", int'(Err), 0);
    tick();

    // reset in the middle of a conversion
    convert_abort: begin
      Hunds = 4'd1; Tens = 4'd2; Units = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("abort_pre_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_bin",  int'(Bin),  0);
      chk("abort_err",  int'(Err),  0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
        tick();
        if (done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end

    convert(4'd9, 4'd9, 4'd9, lat);
    chk("post_abort_latency", lat, BIN_W);
    chk("post_abort_bin", int'(Bin), 999);
    chk("post_abort_err", int'(Err), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
